action_issuer: RTL and testbench

ACTION_ISSUER -- requirements
Module: action_issuer

---
 rtl/action_issuer.sv | 154 +++++++++++++++
 tb/tb_action_issuer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_issuer.sv
// Epsilon-greedy action issuer: picks a random (LFSR) or greedy action per step
// and hands it to the Q-learning pipeline over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; step_count holds the last episode's result
// DRAW  | advance LFSR, decide explore/exploit, load action if possible
// WAITG | exploit chosen but greedy action not yet valid; LFSR held
// ISSUE | action presented until accepted
// DONE  | one-cycle done pulse, then back to IDLE
module action_issuer #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          ACT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      num_steps,
  input  logic [15:0]      epsilon,
  input  logic             greedy_valid,
  input  logic [ACT_W-1:0] greedy_action,
  output logic [ACT_W-1:0] action,
  output logic             action_valid,
  input  logic             action_ready,
  output logic             explore,
  output logic             busy,
  output logic             done,
  output logic [15:0]      step_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
    S_WAITG = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [15:0]      num_steps_q;
  logic [15:0]      step_count_q;
  logic [15:0]      step_count_d;
  logic [ACT_W-1:0] action_q;
  logic             action_valid_q;
  logic             explore_q;
  logic             explore_d;
  logic             busy_q;
  logic             done_q;
  logic             stop_seen_q;
  logic             last_step;

  assign lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign explore_d    = (lfsr_d <= epsilon);
  assign step_count_d = step_count_q + 16'd1;
  assign last_step    = (num_steps_q != 16'd0) && (step_count_d == num_steps_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      lfsr_q         <= SEED;
      num_steps_q    <= 16'd0;
      step_count_q   <= 16'd0;
      action_q       <= '0;
      action_valid_q <= 1'b0;
      explore_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      stop_seen_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_steps_q  <= num_steps;
            step_count_q <= 16'd0;
            stop_seen_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_DRAW;
          end
        end

        S_DRAW: begin
          if (stop) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            lfsr_q    <= lfsr_d;
            explore_q <= explore_d;
            if (explore_d) begin
              action_q       <= lfsr_d[ACT_W-1:0];
              action_valid_q <= 1'b1;
              state_q        <= S_ISSUE;
            end else if (greedy_valid) begin
              action_q       <= greedy_action;
              action_valid_q <= 1'b1;
              state_q        <= S_ISSUE;
            end else begin
              state_q <= S_WAITG;
            end
          end
        end

        S_WAITG: begin
          if (stop) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (greedy_valid) begin
            action_q       <= greedy_action;
            action_valid_q <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // A stop seen while the pipeline stalls only ends the episode once
          // the in-flight action has been accepted.
          if (action_ready) begin
            action_valid_q <= 1'b0;
            step_count_q   <= step_count_d;
            if (stop || stop_seen_q || last_step) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_DRAW;
            end
          end else if (stop) begin
            stop_seen_q <= 1'b1;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          action_valid_q <= 1'b0;
          busy_q         <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  assign action       = action_q;
  assign action_valid = action_valid_q;
  assign explore      = explore_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign step_count   = step_count_q;

endmodule

// File: tb/tb_action_issuer.sv
// Directed bench for action_issuer: latency, explore/exploit choice, stall,
// stop handling, step limits and asynchronous reset.
module tb_action_issuer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] num_steps;
  logic [15:0] epsilon;
  logic        greedy_valid;
  logic [2:0]  greedy_action;
  logic [2:0]  action;
  logic        action_valid;
  logic        action_ready;
  logic        explore;
  logic        busy;
  logic        done;
  logic [15:0] step_count;

  int          checks;
  int          errors;
  logic [15:0] exp_lfsr;

  action_issuer #(.SEED(16'hACE1), .ACT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .num_steps    (num_steps),
    .epsilon      (epsilon),
    .greedy_valid (greedy_valid),
    .greedy_action(greedy_action),
    .action       (action),
    .action_valid (action_valid),
    .action_ready (action_ready),
    .explore      (explore),
    .busy         (busy),
    .done         (done),
    .step_count   (step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic adv();
    exp_lfsr = lfsr_next(exp_lfsr);
  endtask

  // One-step explore episode from the seed: used after power-up and after reset.
  task automatic seed_episode(input string pfx);
    epsilon      = 16'hFFFF;
    num_steps    = 16'd1;
    action_ready = 1'b1;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check({pfx, "_draw_valid"}, action_valid, 0);
    check({pfx, "_draw_busy"}, busy, 1);
    adv();
    tick();
    check({pfx, "_lfsr"}, exp_lfsr, 16'hE270);
    check({pfx, "_valid"}, action_valid, 1);
    check({pfx, "_action"}, action, 0);
    check({pfx, "_explore"}, explore, 1);
    tick();
    check({pfx, "_done"}, done, 1);
    check({pfx, "_valid_drop"}, action_valid, 0);
    check({pfx, "_steps"}, step_count, 1);
    tick();
    check({pfx, "_done_pulse"}, done, 0);
    check({pfx, "_idle_busy"}, busy, 0);
    check({pfx, "_steps_hold"}, step_count, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    num_steps = 16'd0;
    epsilon = 16'd0;
    greedy_valid = 1'b0;
    greedy_action = 3'd0;
    action_ready = 1'b0;
    exp_lfsr = 16'hACE1;

    #12;
    check("rst_valid", action_valid, 0);
    check("rst_action", action, 0);
    check("rst_explore", explore, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_steps", step_count, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    seed_episode("t1");

    // Exploit with no greedy action: sit in WAITG, then take action 5
    epsilon      = 16'd0;
    num_steps    = 16'd1;
    greedy_valid = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    adv();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_wait_valid", action_valid, 0);
      check("t2_wait_busy", busy, 1);
      tick();
    end
    greedy_action = 3'd5;
    greedy_valid  = 1'b1;
    tick();
    greedy_valid = 1'b0;
    check("t2_valid", action_valid, 1);
    check("t2_action", action, 5);
    check("t2_explore", explore, 0);
    tick();
    check("t2_done", done, 1);
    check("t2_steps", step_count, 1);
    tick();

    // Stall for 10 cycles; the draw must come from the LFSR held in WAITG
    epsilon      = 16'hFFFF;
    num_steps    = 16'd1;
    action_ready = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    adv();
    tick();
    check("t3_lfsr", exp_lfsr, 16'h389C);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", action_valid, 1);
      check("t3_hold_action", action, 4);
      check("t3_hold_explore", explore, 1);
      check("t3_hold_steps", step_count, 0);
      start = (i == 3);
      tick();
    end
    start        = 1'b0;
    action_ready = 1'b1;
    tick();
    check("t3_steps", step_count, 1);
    check("t3_done", done, 1);
    check("t3_valid_drop", action_valid, 0);
    tick();
    check("t3_idle_steps", step_count, 1);

    // Unlimited episode, stop raised during the 8th ISSUE
    epsilon   = 16'hFFFF;
    num_steps = 16'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      adv();
      tick();
      check("t4_issue_valid", action_valid, 1);
      check("t4_issue_action", action, {29'd0, exp_lfsr[2:0]});
      tick();
      check("t4_gap_valid", action_valid, 0);
      check("t4_gap_steps", step_count, k);
    end
    adv();
    tick();
    check("t4_8th_valid", action_valid, 1);
    check("t4_8th_steps", step_count, 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_done", done, 1);
    check("t4_steps", step_count, 8);
    tick();
    check("t4_idle_busy", busy, 0);
    check("t4_idle_steps", step_count, 8);

    // Greedy already valid: issue at start+2, limit of 2 steps
    epsilon       = 16'd0;
    num_steps     = 16'd2;
    greedy_action = 3'd3;
    greedy_valid  = 1'b1;
    start         = 1'b1;
    tick();
    start = 1'b0;
    adv();
    tick();
    check("t5_valid", action_valid, 1);
    check("t5_action", action, 3);
    check("t5_explore", explore, 0);
    tick();
    check("t5_gap_valid", action_valid, 0);
    check("t5_gap_done", done, 0);
    check("t5_gap_steps", step_count, 1);
    adv();
    tick();
    check("t5_valid2", action_valid, 1);
    tick();
    check("t5_done", done, 1);
    check("t5_steps", step_count, 2);
    greedy_valid = 1'b0;
    tick();

    // Stop while waiting for the greedy action: no issue
    num_steps = 16'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    adv();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_done", done, 1);
    check("t6_valid", action_valid, 0);
    check("t6_steps", step_count, 0);
    tick();
    check("t6_idle_busy", busy, 0);

    // Reset while an action is presented
    epsilon      = 16'hFFFF;
    num_steps    = 16'd1;
    action_ready = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t7_pre_valid", action_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t7_valid", action_valid, 0);
    check("t7_action", action, 0);
    check("t7_explore", explore, 0);
    check("t7_busy", busy, 0);
    check("t7_done", done, 0);
    check("t7_steps", step_count, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_lfsr = 16'hACE1;
    tick();
    check("t7_idle_valid", action_valid, 0);
    seed_episode("t7r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
